// File: rtl/dnn_pkg.sv
// dnn_pkg: shared FSM state type and sizing constants for the argmax scanner
package dnn_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int CLASS_IDX_W = 4;
endpackage

// File: rtl/dnn_argmax_cmp.sv
// dnn_argmax_cmp: combinational signed compare-and-update of the running best score
//   i_best/i_idx/i_tie : current best score, its index and tie flag
//   i_cand/i_cand_idx  : candidate score and its index
//   o_best/o_idx/o_tie : updated best, index and tie flag
module dnn_argmax_cmp
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int IDX_W = CLASS_IDX_W
) (
    input  logic signed [DATA_WIDTH-1:0] i_best,
    input  logic        [IDX_W-1:0]      i_idx,
    input  logic                         i_tie,
    input  logic signed [DATA_WIDTH-1:0] i_cand,
    input  logic        [IDX_W-1:0]      i_cand_idx,
    output logic signed [DATA_WIDTH-1:0] o_best,
    output logic        [IDX_W-1:0]      o_idx,
    output logic                         o_tie
);
    logic w_gt;
    logic w_eq;
    // Strict greater-than keeps the earlier (lower) index on equal scores.
    always_comb begin
        w_gt   = i_cand > i_best;
        w_eq   = i_cand == i_best;
        o_best = w_gt ? i_cand : i_best;
        o_idx  = w_gt ? i_cand_idx : i_idx;
        o_tie  = w_gt ? 1'b0 : (w_eq ? 1'b1 : i_tie);
    end
endmodule

// File: rtl/dnn_argmax_seq.sv
// dnn_argmax_seq: sequential argmax over latched class scores, one class per cycle
//   clk, rst, clear        : clock, sync active-high reset, sync soft clear
//   dnn_done, dnn_out      : upstream done level and packed scores (class 0 in the LSBs)
//   res_ready / res_valid  : result handshake; res_class/res_score/res_tie held in HOLD
//   overrun                : sticky, a done edge arrived while busy
//   res_count              : accepted results, wraps
//   busy                   : high in SCAN or HOLD
module dnn_argmax_seq
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     dnn_done,
    input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]   dnn_out,
    input  logic                                     res_ready,
    output logic                                     res_valid,
    output logic [CLASS_IDX_W-1:0]                   res_class,
    output logic signed [DATA_WIDTH-1:0]             res_score,
    output logic                                     res_tie,
    output logic                                     overrun,
    output logic [CNT_WIDTH-1:0]                     res_count,
    output logic                                     busy
);
    state_t                               r_state;
    state_t                               w_next;
    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] r_scores;
    logic                                 r_done_d;
    logic signed [DATA_WIDTH-1:0]         r_best;
    logic [CLASS_IDX_W-1:0]               r_idx;
    logic                                 r_tie;
    logic [CLASS_IDX_W-1:0]               r_cnt;
    logic                                 r_overrun;
    logic [CNT_WIDTH-1:0]                 r_count;
    logic                                 w_start;
    logic                                 w_accept;
    logic                                 w_last;
    logic signed [DATA_WIDTH-1:0]         w_best;
    logic [CLASS_IDX_W-1:0]               w_idx;
    logic                                 w_tie;

    dnn_argmax_cmp #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(CLASS_IDX_W)) u_cmp (
        .i_best     (r_best),
        .i_idx      (r_idx),
        .i_tie      (r_tie),
        .i_cand     (r_scores[r_cnt]),
        .i_cand_idx (r_cnt),
        .o_best     (w_best),
        .o_idx      (w_idx),
        .o_tie      (w_tie)
    );

    always_comb begin
        w_start  = dnn_done && !r_done_d;
        w_accept = r_state == HOLD && res_ready;
        w_last   = r_cnt == CLASS_IDX_W'(NUM_CLASSES - 1);
        w_next   = r_state;
        if (r_state == IDLE && w_start) w_next = SCAN;
        if (r_state == SCAN && w_last) w_next = HOLD;
        if (w_accept) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Score snapshot needs no reset: it is only read after a start reloads it.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_start) r_scores <= dnn_out;
    end

    // History resets to 1 so a done level held through reset is not a start.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_done_d  <= 1'b1;
            r_best    <= '0;
            r_idx     <= '0;
            r_tie     <= 1'b0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            r_done_d <= dnn_done;
            if (w_start && r_state != IDLE) r_overrun <= 1'b1;
            if (r_state == IDLE && w_start) begin
                r_best <= dnn_out[0];
                r_idx  <= '0;
                r_tie  <= 1'b0;
                r_cnt  <= CLASS_IDX_W'(1);
            end
            if (r_state == SCAN) begin
                r_best <= w_best;
                r_idx  <= w_idx;
                r_tie  <= w_tie;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_accept) r_count <= r_count + 1'b1;
        end
    end

    assign res_valid = r_state == HOLD;
    assign busy      = r_state != IDLE;
    assign res_class = r_idx;
    assign res_score = r_best;
    assign res_tie   = r_tie;
    assign overrun   = r_overrun;
    assign res_count = r_count;
endmodule

// File: doc/dnn_argmax_seq.md
DNN_ARGMAX_SEQ -- requirements
Module: dnn_argmax_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 2: signed width of each class score.
REQ-002 Parameter NUM_CLASSES, default 10: number of class scores scanned.
REQ-003 Parameter CNT_WIDTH, default 16: width of the classification counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 clear  in  1  synchronous soft clear; same effect as rst, lower priority.
REQ-008 dnn_done  in  1  done level from the upstream inference engine.
REQ-009 dnn_out  in  NUM_CLASSES x DATA_WIDTH signed  class scores; index 0 = digit 0.
REQ-010 res_ready  in  1  consumer accepts the result.
REQ-011 res_valid  out  1  result is held and stable.
REQ-012 res_class  out  4  winning class index.
REQ-013 res_score  out  DATA_WIDTH signed  winning score.
REQ-014 res_tie  out  1  another class equals the winning score.
REQ-015 overrun  out  1  sticky; a dnn_done edge was dropped.
REQ-016 res_count  out  CNT_WIDTH  number of accepted results.
REQ-017 busy  out  1  high in SCAN or HOLD.

Function
REQ-018 The block SHALL run a three-state FSM: IDLE, SCAN, HOLD.
REQ-019 The block SHALL register dnn_done every cycle; a start event is defined as dnn_done=1 while the previous sample was 0.
REQ-020 In IDLE on a start event (cycle T), the block SHALL latch all dnn_out scores, set best=score[0], idx=0, tie=0, cnt=1, and enter SCAN.
REQ-021 In SCAN, each cycle SHALL compare latched score[cnt] against best as signed values: if greater, best/idx update and tie clears; if equal, tie sets; if less, no change.
REQ-022 When cnt=NUM_CLASSES-1 is processed, the block SHALL enter HOLD; res_valid SHALL rise at cycle T+NUM_CLASSES (T+10 by default).
REQ-023 Ties SHALL resolve to the lowest index.
REQ-024 In HOLD, res_class, res_score and res_tie SHALL remain stable until res_valid&&res_ready.
REQ-025 On res_valid&&res_ready, the block SHALL return to IDLE with res_valid=0 on the next cycle, and res_count SHALL increment.
REQ-026 res_count SHALL wrap from all-ones to 0.
REQ-027 A start event in SCAN or HOLD SHALL be ignored and SHALL set overrun; scan data is not disturbed.
REQ-028 A start event in the same cycle as the HOLD handshake SHALL also be dropped and flagged; the next accepted start requires a new 0->1 edge.
REQ-029 res_ready outside HOLD SHALL have no effect.
REQ-030 The latched scores SHALL be used for the scan; dnn_out changes after T SHALL NOT affect the result.

Reset
REQ-031 On rst or clear, the block SHALL set: state=IDLE, res_valid=0, res_class=0, res_score=0, res_tie=0, overrun=0, res_count=0, busy=0, and the dnn_done history=1.
REQ-032 Setting the dnn_done history to 1 SHALL mean a done held high through reset generates no start event.
REQ-033 rst or clear asserted mid-SCAN or mid-HOLD SHALL abort the operation without producing a result.
REQ-034 rst SHALL take priority over clear, and clear over all functional updates.

Structure
REQ-035 Package dnn_pkg SHALL hold the FSM state enum (IDLE/SCAN/HOLD), NUM_CLASSES_DEF=10 and CLASS_IDX_W=4.
REQ-036 The signed compare-and-update SHALL be one sub-module, dnn_argmax_cmp; it is combinational and takes best, idx, tie and the candidate.
REQ-037 All other logic SHALL reside in dnn_argmax_seq; no internal memories or multipliers.

Verification
REQ-038 Scores {0,0,0,1,0,0,0,0,0,0}, done edge at T, ready=1 -> res_valid at T+10, class=3, score=1, tie=0, res_count=1.
REQ-039 All scores -2 -> class=0, score=-2, tie=1.
REQ-040 Scores with 1 at indices 2 and 7, others -1 -> class=2, tie=1; scores with -1 at index 5, others -2 -> class=5, tie=0.
REQ-041 ready=0 for 20 cycles, then a second done edge during HOLD -> outputs stable, overrun=1; after ready, one result only, res_count=1.
REQ-042 rst at T+4 mid-SCAN with done held high -> no res_valid ever; a new 0->1 done edge yields a normal result 10 cycles later.
REQ-043 Preload res_count=0xFFFF via 65535 handshakes (or force), then one more accept -> res_count=0; clear pulse -> overrun=0, res_count=0.
